fpu_issue_ctrl: RTL
===================

Name: fpu_issue_ctrl

Overview:
- Sequential successor to the combinational FPU op decoder.
- Accepts one FP instruction per transaction over a valid/ready handshake. Decodes it for single or double format, with rs2/rm legality checks.
- Issues a one-cycle start to the FPU datapath and tracks the per-op latency with a down-counter.
- Presents a held response (done or illegal) until the writeback stage takes it. Sits between the decode stage and the FPU datapath and writeback.

Parameters:
- SUPPORT_SINGLE, 1: 1 = fmt 00 (.s) legal; 0 = only fmt 01 (.d) legal.
- LAT_ADD, 3: execute cycles for add/sub.
- LAT_MUL, 4: execute cycles for mul.
- LAT_DIV, 16: execute cycles for div.
- LAT_SQRT, 20: execute cycles for sqrt.
- LAT_CVT, 2: execute cycles for int/fp conversions.
- LAT_MV, 1: execute cycles for fmv.
- CNT_W, 5: counter width. Must hold the largest LAT_*. Every LAT_* is >=1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept
- instruction  in  32  raw RV instruction
- flush  in  1  abort current transaction
- fpu_start  out  1  one-cycle issue pulse to datapath
- fpu_op  out  5  decoded op code
- fpu_fmt  out  1  0 = single, 1 = double
- fpu_rm  out  3  rounding mode (instruction[14:12])
- rd_is_fp  out  1  destination is f-register
- rs1_is_fp  out  1  source 1 is f-register
- busy  out  1  state != IDLE
- resp_valid  out  1  response held
- resp_illegal  out  1  response is illegal-instruction
- resp_ready  in  1  writeback accepts response

Behaviour:
- Reset (rst_n=0 at a clk edge, any state): state=IDLE, counter=0, fpu_start=0, fpu_op=5'b11111, fpu_fmt=0, fpu_rm=0, rd_is_fp=0, rs1_is_fp=0, resp_valid=0, resp_illegal=0.
- Reset asserted mid-operation discards the transaction. No response is produced.

Decode (requires opcode 1010011, fmt in {00 if SUPPORT_SINGLE, 01}):
- funct5 00000 -> add 00000
- funct5 00001 -> sub 00001
- funct5 00010 -> mul 00010
- funct5 00011 -> div 00011
- funct5 01011 with rs2=00000 -> sqrt 00100
- funct5 11000 with rs2=00010 -> fcvt.l 00101
- funct5 11000 with rs2=00000 -> fcvt.w 01001
- funct5 11010 with rs2=00010 -> fcvt.*.l 00110
- funct5 11010 with rs2=00000 -> fcvt.*.w 01010
- funct5 11100 with rs2=00000 and funct3=000 -> fmv.x 00111
- funct5 11110 with rs2=00000 and funct3=000 -> fmv.*.x 01000
- For non-fmv ops, rm 101 or 110 is illegal.
- Anything else is illegal: fpu_op=11111.

Register-file flags:
- rd_is_fp=0 for fcvt.l, fcvt.w, fmv.x; else 1.
- rs1_is_fp=0 for fcvt.*.l, fcvt.*.w, fmv.*.x; else 1.
- Both flags are 0 when illegal.

State machine: IDLE, EXEC, RESP.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready, register the decoded outputs.
  - Legal instruction -> EXEC, counter=LAT(op)-1.
  - Illegal instruction -> RESP with resp_illegal=1.
- EXEC:
  - fpu_start=1 only in the first EXEC cycle.
  - Counter decrements each cycle.
  - At counter==0 -> RESP.
- RESP:
  - resp_valid=1.
  - fpu_op, fpu_fmt, fpu_rm and flags held stable.
  - On resp_ready -> IDLE. resp_valid and resp_illegal clear on the next cycle.

Timing:
- Accept at cycle T gives fpu_start at T+1 and resp_valid at T+1+LAT(op).
- Illegal accepted at T gives resp_valid at T+1 and no fpu_start.
- instr_ready=0 outside IDLE, so there is a minimum one-cycle bubble between transactions.
- Decoded outputs hold their values after the return to IDLE until the next accept.

flush:
- In EXEC or RESP: go to IDLE next cycle with no response. resp_valid and fpu_start are forced to 0 that cycle.
- In IDLE: suppresses the accept even if instr_valid=1.
- Reset has priority over flush.

resp_ready held high in advance is legal: RESP then lasts exactly one cycle.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-EXEC of a div -> all outputs at reset values; no resp_valid within 30 cycles.
- fadd.d 0x02208053, resp_ready=1:
  - accept T -> fpu_start at T+1, fpu_op=00000, fpu_fmt=1, rd_is_fp=1, rs1_is_fp=1;
  - resp_valid at T+4, one cycle only.
- fdiv.d, resp_ready=0 until T+25 -> resp_valid from T+17 to T+25, outputs stable throughout; IDLE at T+26.
- fcvt.l.d (funct5 11000, rs2=00010, fmt 01) -> fpu_op=00101, rd_is_fp=0, rs1_is_fp=1, resp at T+3. Same with rs2=00001 -> resp_illegal=1 at T+1, fpu_op=11111, no fpu_start.
- fadd.s (fmt 00):
  - SUPPORT_SINGLE=1 -> fpu_fmt=0, legal.
  - SUPPORT_SINGLE=0 -> illegal.
  - fadd.d with rm=101 -> illegal.
- flush at the third EXEC cycle of fsqrt.d -> IDLE next cycle, no resp_valid. A following fmv.x.d is accepted and responds at T+2 with rd_is_fp=0.

Source files
------------

// File: rtl/fpu_issue_ctrl.sv
// FP instruction issue controller: decodes one RV FP op per handshake, pulses the
// datapath start, times the op latency with a down-counter and holds the response.
module fpu_issue_ctrl #(
  parameter bit SUPPORT_SINGLE = 1'b1,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 16,
  parameter int LAT_SQRT = 20,
  parameter int LAT_CVT  = 2,
  parameter int LAT_MV   = 1,
  parameter int CNT_W    = 5
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instruction_i,
  input  logic        flush_i,
  output logic        fpu_start_o,
  output logic [4:0]  fpu_op_o,
  output logic        fpu_fmt_o,
  output logic [2:0]  fpu_rm_o,
  output logic        rd_is_fp_o,
  output logic        rs1_is_fp_o,
  output logic        busy_o,
  output logic        resp_valid_o,
  output logic        resp_illegal_o,
  input  logic        resp_ready_i
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_DIV   = 5'b00011;
  localparam logic [4:0] OP_SQRT  = 5'b00100;
  localparam logic [4:0] OP_CVTL  = 5'b00101;
  localparam logic [4:0] OP_CVTFL = 5'b00110;
  localparam logic [4:0] OP_MVX   = 5'b00111;
  localparam logic [4:0] OP_MVF   = 5'b01000;
  localparam logic [4:0] OP_CVTW  = 5'b01001;
  localparam logic [4:0] OP_CVTFW = 5'b01010;
  localparam logic [4:0] OP_ILL   = 5'b11111;

  // Counter preloads are latency-1 so the last EXEC cycle sees zero.
  localparam logic [CNT_W-1:0] C_ADD  = CNT_W'(LAT_ADD - 1);
  localparam logic [CNT_W-1:0] C_MUL  = CNT_W'(LAT_MUL - 1);
  localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] C_SQRT = CNT_W'(LAT_SQRT - 1);
  localparam logic [CNT_W-1:0] C_CVT  = CNT_W'(LAT_CVT - 1);
  localparam logic [CNT_W-1:0] C_MV   = CNT_W'(LAT_MV - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q, fmt_q, rd_fp_q, rs1_fp_q, resp_valid_q, resp_ill_q;
  logic [4:0]       op_q;
  logic [2:0]       rm_q;

  logic [4:0]       funct5, rs2;
  logic [1:0]       fmt;
  logic [2:0]       rm;
  logic [4:0]       dec_op;
  logic             dec_legal, dec_rd_fp, dec_rs1_fp;
  logic [CNT_W-1:0] dec_cnt;
  logic             unused_bits;

  assign funct5      = instruction_i[31:27];
  assign fmt         = instruction_i[26:25];
  assign rs2         = instruction_i[24:20];
  assign rm          = instruction_i[14:12];
  assign unused_bits = ^{instruction_i[19:15], instruction_i[11:7]};

  always_comb begin
    dec_op = OP_ILL;
    if (instruction_i[6:0] == 7'b1010011 &&
        (fmt == 2'b01 || (SUPPORT_SINGLE && fmt == 2'b00))) begin
      case (funct5)
        5'b00000: dec_op = OP_ADD;
        5'b00001: dec_op = OP_SUB;
        5'b00010: dec_op = OP_MUL;
        5'b00011: dec_op = OP_DIV;
        5'b01011: if (rs2 == 5'b00000) dec_op = OP_SQRT;
        5'b11000: begin
          if (rs2 == 5'b00010)      dec_op = OP_CVTL;
          else if (rs2 == 5'b00000) dec_op = OP_CVTW;
        end
        5'b11010: begin
          if (rs2 == 5'b00010)      dec_op = OP_CVTFL;
          else if (rs2 == 5'b00000) dec_op = OP_CVTFW;
        end
        5'b11100: if (rs2 == 5'b00000 && rm == 3'b000) dec_op = OP_MVX;
        5'b11110: if (rs2 == 5'b00000 && rm == 3'b000) dec_op = OP_MVF;
        default:  dec_op = OP_ILL;
      endcase
      // Reserved rounding modes only matter where rm is actually a rounding mode.
      if (dec_op != OP_MVX && dec_op != OP_MVF && (rm == 3'b101 || rm == 3'b110))
        dec_op = OP_ILL;
    end
    dec_legal  = (dec_op != OP_ILL);
    dec_rd_fp  = dec_legal && !(dec_op == OP_CVTL || dec_op == OP_CVTW || dec_op == OP_MVX);
    dec_rs1_fp = dec_legal && !(dec_op == OP_CVTFL || dec_op == OP_CVTFW || dec_op == OP_MVF);
    case (dec_op)
      OP_ADD, OP_SUB:                        dec_cnt = C_ADD;
      OP_MUL:                                dec_cnt = C_MUL;
      OP_DIV:                                dec_cnt = C_DIV;
      OP_SQRT:                               dec_cnt = C_SQRT;
      OP_CVTL, OP_CVTW, OP_CVTFL, OP_CVTFW:  dec_cnt = C_CVT;
      OP_MVX, OP_MVF:                        dec_cnt = C_MV;
      default:                               dec_cnt = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      op_q         <= OP_ILL;
      fmt_q        <= 1'b0;
      rm_q         <= 3'b000;
      rd_fp_q      <= 1'b0;
      rs1_fp_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_ill_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (instr_valid_i && !flush_i) begin
            op_q     <= dec_op;
            fmt_q    <= dec_legal & fmt[0];
            rm_q     <= rm;
            rd_fp_q  <= dec_rd_fp;
            rs1_fp_q <= dec_rs1_fp;
            if (dec_legal) begin
              state_q <= EXEC;
              cnt_q   <= dec_cnt;
              start_q <= 1'b1;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_ill_q   <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_ill_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (flush_i || resp_ready_i) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_ill_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flush must kill a pending start or response in the very cycle it is raised.
  assign fpu_start_o    = start_q & ~flush_i;
  assign resp_valid_o   = resp_valid_q & ~flush_i;
  assign resp_illegal_o = resp_ill_q;
  assign instr_ready_o  = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign fpu_op_o       = op_q;
  assign fpu_fmt_o      = fmt_q;
  assign fpu_rm_o       = rm_q;
  assign rd_is_fp_o     = rd_fp_q;
  assign rs1_is_fp_o    = rs1_fp_q;

endmodule
